lamp_fpu_cmp_issue: RTL and testbench
=====================================

# lamp_fpu_cmp_issue

Issue and retire front-end for the bfloat16 compare unit. It accepts a packed compare request (opcode plus two raw 16-bit operands) over a valid/ready handshake. It unpacks and classifies both operands, drives one single-cycle `do*` strobe with registered operand fields into the compare unit, and captures the registered result. It returns that result over a second valid/ready handshake and maintains a sticky invalid-operation (NV) flag.

## Interface
- `TIMEOUT_CYC`, default 8: maximum WAIT cycles before a timeout response; legal range 2..15.
- `clk`  in  1  clock.
- `rst`  in  1  **synchronous, active-high reset.**
- `req_valid_i` / `req_ready_o`  in / out  1 / 1  request handshake.
- `opcode_i`  in  2  compare opcode: 00 EQ, 01 LT, 10 LE, 11 illegal.
- `opA_i`, `opB_i`  in  16  raw bfloat16 operands.
- `doEq_o`, `doLt_o`, `doLe_o`  out  1  one-cycle strobes to the compare unit.
- `opASign_o`/`opBSign_o`  out  1; `opAExp_o`/`opBExp_o`  out  8; `opAFract_o`/`opBFract_o`  out  7  unpacked fields.
- `isAZer_o`, `isASNaN_o`, `isAQNaN_o`, `isBZer_o`, `isBSNaN_o`, `isBQNaN_o`  out  1  classification.
- `cmp_i`, `isCmpValid_i`, `isCmpInvalid_i`  in  1  registered compare-unit outputs.
- `res_valid_o` / `res_ready_i`  out / in  1 / 1  response handshake.
- `res_o`  out  1  compare result.
- `resInvalid_o`  out  1  per-op NV flag.
- `resIllegal_o`  out  1  per-op illegal-opcode flag.
- `resTimeout_o`  out  1  per-op timeout flag.
- `flagNV_o`  out  1  sticky NV flag.
- `flagClr_i`  in  1  clears `flagNV_o`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `req_ready_o`=1.
  - On `req_valid_i`: latch operands and opcode.
  - Legal opcode goes to ISSUE.
  - Opcode 11 goes to RESP with `res_o`=0 and `resIllegal_o`=1. No strobe is ever driven.
- **ISSUE:** exactly one `do*` bit is high for one cycle, then go to WAIT. Operand and classification outputs are registered and held stable from ISSUE through WAIT.
- **WAIT:** a 4-bit counter starts at 0.
  - On `isCmpValid_i`: capture `cmp_i` to `res_o` and `isCmpInvalid_i` to `resInvalid_o`, then go to RESP.
  - If the counter reaches `TIMEOUT_CYC` first: go to RESP with `res_o`=0 and `resTimeout_o`=1.
- **RESP:** `res_valid_o`=1, with all `res*` outputs held. On `res_ready_i`, go to IDLE.
- Classification, per operand (E = 8-bit exponent, F = 7-bit fraction):
  - Zero: E==0 and F==0.
  - NaN: E==0xFF and F!=0.
  - QNaN: NaN with F[6]=1.
  - SNaN: NaN with F[6]=0.
  - Infinity and normal values: all class flags 0.
- Sticky NV:
  - Set on the RESP handshake cycle when `resInvalid_o`=1.
  - Cleared by `flagClr_i`.
  - If set and clear happen in the same cycle, set wins.
- `req_ready_o` is 0 in every state except IDLE, so only one op is in flight.

## Timing
- Reset value of every output is 0, including `flagNV_o` and all strobes; the FSM resets to IDLE.
- A reset in any state aborts the op and returns to IDLE the next cycle. No response is produced for the aborted op.
- Latency, with the request accepted at edge 0:
  - ISSUE occupies cycle 1.
  - The compare unit asserts `isCmpValid_i` in cycle 2.
  - `res_valid_o` rises in cycle 3.
  - Minimum issue-to-issue interval is 4 cycles.
- Illegal opcode: `res_valid_o` rises in cycle 1.
- `isCmpValid_i` outside WAIT is ignored.
- The timeout counter saturates; it does not wrap.

## Configuration
- `LAMP_FPU_DENORM_FLUSH_EN`:
  - **Defined:** an operand with E==0 and F!=0 is flushed. Its `isZer` is 1, its fraction output is forced to 0, and its sign is kept.
  - **Undefined:** denormals pass through unchanged with `isZer`=0.

## Structure
- Shared package `lampFPU_pkg` holds:
  - The `LAMP_FLOAT_S_DW`/`E_DW`/`F_DW` widths.
  - A `cmpOpcode_t` enum (EQ, LT, LE, ILL).
  - A `cmpIssueState_t` enum.
- One sub-module, `lamp_fpu_cmp_classify`: combinational unpack and classify of one operand, instantiated twice.

## Test plan
- LT, A=0x3F80, B=0x4000 → exactly one `doLt_o` pulse in cycle 1; `res_valid_o` in cycle 3 with `res_o`=1 and `resInvalid_o`=0.
- EQ, A=0x0000, B=0x8000 → `isAZer_o`=`isBZer_o`=1; `res_o`=1.
- LE, A=0x7FC0, B=0x3F80 → `isAQNaN_o`=1; `res_o`=0, `resInvalid_o`=1, `flagNV_o` rises after the handshake. Pulse `flagClr_i` together with a second invalid handshake → `flagNV_o` stays 1. Pulse `flagClr_i` alone → `flagNV_o`=0.
- Opcode 11 → no `do*` strobe; `res_valid_o` in cycle 1 with `resIllegal_o`=1. Then hold `res_ready_i`=0 for 5 cycles → `res_valid_o` stays high and `req_ready_o`=0 throughout.
- Tie `isCmpValid_i`=0, EQ request → `resTimeout_o`=1 after 8 WAIT cycles. Assert `rst` during WAIT → all outputs 0 and FSM in IDLE next cycle.
- EQ, A=0x0001, B=0x0000 → `res_o`=1 with `LAMP_FPU_DENORM_FLUSH_EN` defined; `res_o`=0 without it.

Source files
------------

// File: rtl/lamp_fpu_cmp_issue_pkg.sv
// ---------------------------------------------------------------------------
// lampFPU_pkg
// Shared definitions for the bfloat16 compare issue/retire front-end:
//   - field widths of the packed bfloat16 format (sign / exponent / fraction)
//   - cmpOpcode_t      : compare opcode encoding (EQ, LT, LE, ILL)
//   - cmpIssueState_t  : state encoding of the issue/retire sequencer
// ---------------------------------------------------------------------------
package lampFPU_pkg;

  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_LT  = 2'b01,
    CMP_LE  = 2'b10,
    CMP_ILL = 2'b11
  } cmpOpcode_t;

  typedef enum logic [1:0] {
    CMP_ST_IDLE  = 2'b00,
    CMP_ST_ISSUE = 2'b01,
    CMP_ST_WAIT  = 2'b10,
    CMP_ST_RESP  = 2'b11
  } cmpIssueState_t;

endpackage

// File: rtl/lamp_fpu_cmp_classify.sv
// ---------------------------------------------------------------------------
// lamp_fpu_cmp_classify
// Combinational unpack and classification of one raw bfloat16 operand.
// Build option: LAMP_FPU_DENORM_FLUSH_EN -- when defined, a denormal
// (E==0, F!=0) is reported as zero with its fraction forced to 0 and its
// sign kept; when undefined, denormals pass through with isZer=0.
// Ports:
//   op       in  16  raw operand
//   opSign   out  1  sign bit
//   opExp    out  8  biased exponent
//   opFract  out  7  fraction (zeroed for flushed denormals)
//   isZer    out  1  operand is +/-0 (or a flushed denormal)
//   isSNaN   out  1  signalling NaN (quiet bit F[6] clear)
//   isQNaN   out  1  quiet NaN (quiet bit F[6] set)
// ---------------------------------------------------------------------------
module lamp_fpu_cmp_classify
  import lampFPU_pkg::*;
(
  input  logic [LAMP_FLOAT_DW-1:0]   op,
  output logic                       opSign,
  output logic [LAMP_FLOAT_E_DW-1:0] opExp,
  output logic [LAMP_FLOAT_F_DW-1:0] opFract,
  output logic                       isZer,
  output logic                       isSNaN,
  output logic                       isQNaN
);

  logic [LAMP_FLOAT_E_DW-1:0] rawExp_s;
  logic [LAMP_FLOAT_F_DW-1:0] rawFract_s;
  logic                       expZero_s;
  logic                       expOnes_s;
  logic                       fractZero_s;
  logic                       isNaN_s;

  // Split the operand into fields and derive the class flags.
  always_comb begin
    rawExp_s    = op[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
    rawFract_s  = op[LAMP_FLOAT_F_DW-1:0];
    expZero_s   = (rawExp_s == 8'h00);
    expOnes_s   = (rawExp_s == 8'hFF);
    fractZero_s = (rawFract_s == 7'h00);
    isNaN_s     = expOnes_s & ~fractZero_s;

    opSign = op[LAMP_FLOAT_DW-1];
    opExp  = rawExp_s;
    // F[6] is the quiet bit of a bfloat16 NaN.
    isQNaN = isNaN_s & rawFract_s[LAMP_FLOAT_F_DW-1];
    isSNaN = isNaN_s & ~rawFract_s[LAMP_FLOAT_F_DW-1];
`ifdef LAMP_FPU_DENORM_FLUSH_EN
    // Any E==0 operand behaves as zero; its fraction is dropped.
    if (expZero_s) begin
      opFract = 7'h00;
      isZer   = 1'b1;
    end else begin
      opFract = rawFract_s;
      isZer   = 1'b0;
    end
`else
    opFract = rawFract_s;
    isZer   = expZero_s & fractZero_s;
`endif
  end

endmodule

// File: rtl/lamp_fpu_cmp_issue.sv
// ---------------------------------------------------------------------------
// lamp_fpu_cmp_issue
// Issue/retire front-end for the bfloat16 compare unit. Accepts one compare
// request at a time, drives a single-cycle do* strobe with registered
// operand fields and classes, waits (bounded by TIMEOUT_CYC) for the
// compare unit's result and returns it over a valid/ready handshake. Keeps
// a sticky invalid-operation flag.
// Build option: LAMP_FPU_DENORM_FLUSH_EN (see lamp_fpu_cmp_classify).
// Parameter: TIMEOUT_CYC (2..15) -- WAIT cycles before a timeout response.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid_i / req_ready_o      request handshake (ready only in IDLE)
//   opcode_i [1:0]                 00 EQ, 01 LT, 10 LE, 11 illegal
//   opA_i, opB_i [15:0]            raw bfloat16 operands
//   doEq_o, doLt_o, doLe_o         one-cycle strobes to the compare unit
//   opA*/opB* Sign/Exp/Fract       registered unpacked operand fields
//   isA*/isB* Zer/SNaN/QNaN        registered operand classes
//   cmp_i, isCmpValid_i,
//   isCmpInvalid_i                 compare-unit result
//   res_valid_o / res_ready_i      response handshake
//   res_o, resInvalid_o,
//   resIllegal_o, resTimeout_o     per-op result and status
//   flagNV_o / flagClr_i           sticky NV flag and its clear
// ---------------------------------------------------------------------------
module lamp_fpu_cmp_issue
  import lampFPU_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 opcode_i,
  input  logic [LAMP_FLOAT_DW-1:0]   opA_i,
  input  logic [LAMP_FLOAT_DW-1:0]   opB_i,
  output logic                       doEq_o,
  output logic                       doLt_o,
  output logic                       doLe_o,
  output logic                       opASign_o,
  output logic [LAMP_FLOAT_E_DW-1:0] opAExp_o,
  output logic [LAMP_FLOAT_F_DW-1:0] opAFract_o,
  output logic                       opBSign_o,
  output logic [LAMP_FLOAT_E_DW-1:0] opBExp_o,
  output logic [LAMP_FLOAT_F_DW-1:0] opBFract_o,
  output logic                       isAZer_o,
  output logic                       isASNaN_o,
  output logic                       isAQNaN_o,
  output logic                       isBZer_o,
  output logic                       isBSNaN_o,
  output logic                       isBQNaN_o,
  input  logic                       cmp_i,
  input  logic                       isCmpValid_i,
  input  logic                       isCmpInvalid_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       res_o,
  output logic                       resInvalid_o,
  output logic                       resIllegal_o,
  output logic                       resTimeout_o,
  output logic                       flagNV_o,
  input  logic                       flagClr_i
);

  localparam logic [1:0] S_IDLE  = CMP_ST_IDLE;
  localparam logic [1:0] S_ISSUE = CMP_ST_ISSUE;
  localparam logic [1:0] S_WAIT  = CMP_ST_WAIT;
  localparam logic [1:0] S_RESP  = CMP_ST_RESP;

  // Counter value of the last WAIT cycle before a timeout is declared.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYC - 1);

  logic [1:0] state_r;
  logic [1:0] nextState_s;
  logic [3:0] waitCnt_r;
  logic       accept_s;
  logic       handshake_s;
  logic       legalOp_s;
  logic       timeoutHit_s;

  // Combinational classification of the raw inputs, registered on accept.
  logic                       aSign_s, bSign_s;
  logic [LAMP_FLOAT_E_DW-1:0] aExp_s, bExp_s;
  logic [LAMP_FLOAT_F_DW-1:0] aFract_s, bFract_s;
  logic                       aZer_s, aSNaN_s, aQNaN_s;
  logic                       bZer_s, bSNaN_s, bQNaN_s;

  // Output registers.
  logic                       reqReady_r;
  logic                       doEq_r, doLt_r, doLe_r;
  logic                       aSign_r, bSign_r;
  logic [LAMP_FLOAT_E_DW-1:0] aExp_r, bExp_r;
  logic [LAMP_FLOAT_F_DW-1:0] aFract_r, bFract_r;
  logic                       aZer_r, aSNaN_r, aQNaN_r;
  logic                       bZer_r, bSNaN_r, bQNaN_r;
  logic                       resValid_r, res_r, resInvalid_r, resIllegal_r, resTimeout_r;
  logic                       flagNV_r;

  lamp_fpu_cmp_classify uClassA (
    .op      (opA_i),
    .opSign  (aSign_s),
    .opExp   (aExp_s),
    .opFract (aFract_s),
    .isZer   (aZer_s),
    .isSNaN  (aSNaN_s),
    .isQNaN  (aQNaN_s)
  );

  lamp_fpu_cmp_classify uClassB (
    .op      (opB_i),
    .opSign  (bSign_s),
    .opExp   (bExp_s),
    .opFract (bFract_s),
    .isZer   (bZer_s),
    .isSNaN  (bSNaN_s),
    .isQNaN  (bQNaN_s)
  );

  // Handshake and timeout qualifiers.
  always_comb begin
    // reqReady_r stays low for the first IDLE cycle after reset.
    accept_s     = (state_r == S_IDLE) & reqReady_r & req_valid_i;
    handshake_s  = (state_r == S_RESP) & res_ready_i;
    legalOp_s    = (opcode_i != CMP_ILL);
    timeoutHit_s = (waitCnt_r >= WAIT_LAST);
  end

  // Next-state selection of the issue/retire sequence.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (legalOp_s) begin
            nextState_s = S_ISSUE;
          end else begin
            nextState_s = S_RESP;
          end
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_ISSUE: nextState_s = S_WAIT;
      S_WAIT: begin
        if (isCmpValid_i || timeoutHit_s) begin
          nextState_s = S_RESP;
        end else begin
          nextState_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (res_ready_i) begin
          nextState_s = S_IDLE;
        end else begin
          nextState_s = S_RESP;
        end
      end
      default: nextState_s = S_IDLE;
    endcase
  end

  // State register and registered request-ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      reqReady_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      reqReady_r <= (nextState_s == S_IDLE);
    end
  end

  // One-cycle compare strobe, decoded from the opcode at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      doEq_r <= 1'b0;
      doLt_r <= 1'b0;
      doLe_r <= 1'b0;
    end else if (accept_s) begin
      doEq_r <= (opcode_i == CMP_EQ);
      doLt_r <= (opcode_i == CMP_LT);
      doLe_r <= (opcode_i == CMP_LE);
    end else begin
      doEq_r <= 1'b0;
      doLt_r <= 1'b0;
      doLe_r <= 1'b0;
    end
  end

  // Operand fields and classes, latched on acceptance and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      aSign_r  <= 1'b0;
      aExp_r   <= 8'h00;
      aFract_r <= 7'h00;
      aZer_r   <= 1'b0;
      aSNaN_r  <= 1'b0;
      aQNaN_r  <= 1'b0;
      bSign_r  <= 1'b0;
      bExp_r   <= 8'h00;
      bFract_r <= 7'h00;
      bZer_r   <= 1'b0;
      bSNaN_r  <= 1'b0;
      bQNaN_r  <= 1'b0;
    end else if (accept_s) begin
      aSign_r  <= aSign_s;
      aExp_r   <= aExp_s;
      aFract_r <= aFract_s;
      aZer_r   <= aZer_s;
      aSNaN_r  <= aSNaN_s;
      aQNaN_r  <= aQNaN_s;
      bSign_r  <= bSign_s;
      bExp_r   <= bExp_s;
      bFract_r <= bFract_s;
      bZer_r   <= bZer_s;
      bSNaN_r  <= bSNaN_s;
      bQNaN_r  <= bQNaN_s;
    end
  end

  // WAIT-cycle counter: cleared outside WAIT, saturating inside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt_r <= 4'd0;
    end else if (state_r != S_WAIT) begin
      waitCnt_r <= 4'd0;
    end else if (waitCnt_r != 4'hF) begin
      waitCnt_r <= waitCnt_r + 4'd1;
    end
  end

  // Response capture: illegal opcode, compare result or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      resValid_r   <= 1'b0;
      res_r        <= 1'b0;
      resInvalid_r <= 1'b0;
      resIllegal_r <= 1'b0;
      resTimeout_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            resValid_r   <= ~legalOp_s;
            res_r        <= 1'b0;
            resInvalid_r <= 1'b0;
            resIllegal_r <= ~legalOp_s;
            resTimeout_r <= 1'b0;
          end
        end
        S_WAIT: begin
          // A result arriving in the last WAIT cycle beats the timeout.
          if (isCmpValid_i) begin
            resValid_r   <= 1'b1;
            res_r        <= cmp_i;
            resInvalid_r <= isCmpInvalid_i;
          end else if (timeoutHit_s) begin
            resValid_r   <= 1'b1;
            res_r        <= 1'b0;
            resTimeout_r <= 1'b1;
          end
        end
        S_RESP: begin
          if (res_ready_i) begin
            resValid_r <= 1'b0;
          end
        end
        default: begin
          resValid_r <= resValid_r;
        end
      endcase
    end
  end

  // Sticky NV flag; a set on the handshake wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flagNV_r <= 1'b0;
    end else if (handshake_s && resInvalid_r) begin
      flagNV_r <= 1'b1;
    end else if (flagClr_i) begin
      flagNV_r <= 1'b0;
    end
  end

  assign req_ready_o  = reqReady_r;
  assign doEq_o       = doEq_r;
  assign doLt_o       = doLt_r;
  assign doLe_o       = doLe_r;
  assign opASign_o    = aSign_r;
  assign opAExp_o     = aExp_r;
  assign opAFract_o   = aFract_r;
  assign opBSign_o    = bSign_r;
  assign opBExp_o     = bExp_r;
  assign opBFract_o   = bFract_r;
  assign isAZer_o     = aZer_r;
  assign isASNaN_o    = aSNaN_r;
  assign isAQNaN_o    = aQNaN_r;
  assign isBZer_o     = bZer_r;
  assign isBSNaN_o    = bSNaN_r;
  assign isBQNaN_o    = bQNaN_r;
  assign res_valid_o  = resValid_r;
  assign res_o        = res_r;
  assign resInvalid_o = resInvalid_r;
  assign resIllegal_o = resIllegal_r;
  assign resTimeout_o = resTimeout_r;
  assign flagNV_o     = flagNV_r;

endmodule

// File: tb/tb_lamp_fpu_cmp_issue.sv
// ---------------------------------------------------------------------------
// tb_lamp_fpu_cmp_issue
// Self-checking bench: a directed vector table, hand sequences for sticky
// NV, illegal back-pressure and mid-flight reset, then randomized requests.
// The bench plays the compare unit, computing results from real-valued
// bfloat16 semantics.
// ---------------------------------------------------------------------------
module tb_lamp_fpu_cmp_issue;
  import lampFPU_pkg::*;

  localparam int TO = 8;
`ifdef LAMP_FPU_DENORM_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  opcode_i = 2'd0;
  logic [15:0] opA_i = 16'h0000;
  logic [15:0] opB_i = 16'h0000;
  logic        doEq_o, doLt_o, doLe_o;
  logic        opASign_o, opBSign_o;
  logic [7:0]  opAExp_o, opBExp_o;
  logic [6:0]  opAFract_o, opBFract_o;
  logic        isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o;
  logic        cmp_i = 1'b0;
  logic        isCmpValid_i = 1'b0;
  logic        isCmpInvalid_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic        res_o, resInvalid_o, resIllegal_o, resTimeout_o;
  logic        flagNV_o;
  logic        flagClr_i = 1'b0;
  logic [47:0] allOuts;

  int checks = 0;
  int errors = 0;
  bit nvModel = 1'b0;

  always #5 clk = ~clk;

  lamp_fpu_cmp_issue #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opcode_i(opcode_i), .opA_i(opA_i), .opB_i(opB_i),
    .doEq_o(doEq_o), .doLt_o(doLt_o), .doLe_o(doLe_o),
    .opASign_o(opASign_o), .opAExp_o(opAExp_o), .opAFract_o(opAFract_o),
    .opBSign_o(opBSign_o), .opBExp_o(opBExp_o), .opBFract_o(opBFract_o),
    .isAZer_o(isAZer_o), .isASNaN_o(isASNaN_o), .isAQNaN_o(isAQNaN_o),
    .isBZer_o(isBZer_o), .isBSNaN_o(isBSNaN_o), .isBQNaN_o(isBQNaN_o),
    .cmp_i(cmp_i), .isCmpValid_i(isCmpValid_i), .isCmpInvalid_i(isCmpInvalid_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .resInvalid_o(resInvalid_o), .resIllegal_o(resIllegal_o),
    .resTimeout_o(resTimeout_o), .flagNV_o(flagNV_o), .flagClr_i(flagClr_i)
  );

  assign allOuts = {req_ready_o, doEq_o, doLt_o, doLe_o,
                    opASign_o, opAExp_o, opAFract_o, opBSign_o, opBExp_o, opBFract_o,
                    isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o,
                    res_valid_o, res_o, resInvalid_o, resIllegal_o, resTimeout_o, flagNV_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (value-level bfloat16) ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) begin
      for (int i = 0; i < n; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -n; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic bit isNaN(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
  endfunction

  function automatic bit isSNaN(input logic [15:0] x);
    return isNaN(x) && !x[6];
  endfunction

  function automatic bit isQNaN(input logic [15:0] x);
    return isNaN(x) && x[6];
  endfunction

  function automatic real fval(input logic [15:0] x);
    int  e = int'({24'd0, x[14:7]});
    int  f = int'({25'd0, x[6:0]});
    real mag;
    if (e == 255) mag = 1.0e300;
    else if (e == 0) mag = FLUSH ? 0.0 : (real'(f) / 128.0) * pow2(-126);
    else mag = (1.0 + real'(f) / 128.0) * pow2(e - 127);
    return x[15] ? -mag : mag;
  endfunction

  function automatic bit expZer(input logic [15:0] x);
    return (x[14:7] == 8'h00) && ((x[6:0] == 7'h00) || FLUSH);
  endfunction

  function automatic logic [6:0] expFract(input logic [15:0] x);
    return (FLUSH && (x[14:7] == 8'h00)) ? 7'h00 : x[6:0];
  endfunction

  task automatic refCmp(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output bit res, output bit inv);
    bit anyNaN = isNaN(a) || isNaN(b);
    case (op)
      2'd0: begin inv = isSNaN(a) || isSNaN(b); res = !anyNaN && (fval(a) == fval(b)); end
      2'd1: begin inv = anyNaN; res = !anyNaN && (fval(a) <  fval(b)); end
      2'd2: begin inv = anyNaN; res = !anyNaN && (fval(a) <= fval(b)); end
      default: begin inv = 1'b0; res = 1'b0; end
    endcase
  endtask

  task automatic chkFields(input string tag, input logic [15:0] a, input logic [15:0] b);
    chk({tag, " A sign"},  64'(opASign_o),  64'(a[15]));
    chk({tag, " A exp"},   64'(opAExp_o),   64'(a[14:7]));
    chk({tag, " A fract"}, 64'(opAFract_o), 64'(expFract(a)));
    chk({tag, " A class"}, 64'({isAZer_o, isASNaN_o, isAQNaN_o}),
        64'({expZer(a), isSNaN(a), isQNaN(a)}));
    chk({tag, " B sign"},  64'(opBSign_o),  64'(b[15]));
    chk({tag, " B exp"},   64'(opBExp_o),   64'(b[14:7]));
    chk({tag, " B fract"}, 64'(opBFract_o), 64'(expFract(b)));
    chk({tag, " B class"}, 64'({isBZer_o, isBSNaN_o, isBQNaN_o}),
        64'({expZer(b), isSNaN(b), isQNaN(b)}));
  endtask

  // One full request/response transaction. lat = WAIT cycle index in which
  // the compare unit answers (>= TO means never); rdy = RESP stall cycles.
  task automatic runOp(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int lat, input int rdy, input bit clr,
                       output bit gotRes, output bit gotInv, output bit gotIll, output bit gotTo);
    bit mRes, mInv, illegal, timeout, eRes, eInv;
    int cyc;
    refCmp(op, a, b, mRes, mInv);
    illegal = (op == 2'b11);
    timeout = !illegal && (lat >= TO);
    eRes = (illegal || timeout) ? 1'b0 : mRes;
    eInv = (illegal || timeout) ? 1'b0 : mInv;
    chk("ready before request", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; opcode_i = op; opA_i = a; opB_i = b;
    step();
    req_valid_i = 1'b0;
    opcode_i = 2'($urandom); opA_i = 16'($urandom); opB_i = 16'($urandom);
    cyc = 1;
    if (illegal) begin
      chk("illegal no strobe", 64'({doLe_o, doLt_o, doEq_o}), 64'd0);
      chk("illegal resp cycle1", 64'(res_valid_o), 64'd1);
    end else begin
      chk("strobe one-hot", 64'({doLe_o, doLt_o, doEq_o}), 64'(3'b001 << op));
      chkFields("issue", a, b);
      chk("ready low in issue", 64'(req_ready_o), 64'd0);
      step();
      cyc = 2;
      chk("strobe single pulse", 64'({doLe_o, doLt_o, doEq_o}), 64'd0);
      while (!res_valid_o && cyc < 40) begin
        chkFields("wait", a, b);
        if (cyc - 2 == lat) begin
          isCmpValid_i = 1'b1; cmp_i = mRes; isCmpInvalid_i = mInv;
        end
        step();
        isCmpValid_i = 1'b0; cmp_i = 1'b0; isCmpInvalid_i = 1'b0;
        cyc++;
      end
      chk("response cycle", 64'(cyc), 64'(timeout ? 2 + TO : 3 + lat));
    end
    chk("resp valid", 64'(res_valid_o), 64'd1);
    chk("res", 64'(res_o), 64'(eRes));
    chk("resInvalid", 64'(resInvalid_o), 64'(eInv));
    chk("resIllegal", 64'(resIllegal_o), 64'(illegal));
    chk("resTimeout", 64'(resTimeout_o), 64'(timeout));
    gotRes = res_o; gotInv = resInvalid_o; gotIll = resIllegal_o; gotTo = resTimeout_o;
    for (int d = 0; d < rdy; d++) begin
      // Stray compare-unit results in RESP must not disturb the response.
      isCmpValid_i = 1'b1; cmp_i = ~eRes; isCmpInvalid_i = ~eInv;
      step();
      isCmpValid_i = 1'b0; cmp_i = 1'b0; isCmpInvalid_i = 1'b0;
      chk("stall valid held", 64'(res_valid_o), 64'd1);
      chk("stall res held", 64'({res_o, resInvalid_o, resIllegal_o, resTimeout_o}),
          64'({eRes, eInv, illegal, timeout}));
      chk("stall ready low", 64'(req_ready_o), 64'd0);
    end
    res_ready_i = 1'b1; flagClr_i = clr;
    step();
    res_ready_i = 1'b0; flagClr_i = 1'b0;
    if (eInv) nvModel = 1'b1;
    else if (clr) nvModel = 1'b0;
    chk("valid drops after handshake", 64'(res_valid_o), 64'd0);
    chk("sticky NV", 64'(flagNV_o), 64'(nvModel));
    chk("ready after handshake", 64'(req_ready_o), 64'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    int          rdy;
    bit          clr;
    bit          eRes;
    bit          eInv;
    bit          eIll;
    bit          eTo;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gRes, gInv, gIll, gTo;
    logic [15:0] specials[11];

    tbl[0] = '{2'd1, 16'h3F80, 16'h4000, 0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 16'h0000, 16'h8000, 1,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'd2, 16'h7FC0, 16'h3F80, 0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'd0, 16'h7F81, 16'h3F80, 2,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2'd0, 16'h0001, 16'h0000, 0,  0, 1'b0, FLUSH, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2'd3, 16'h1234, 16'h5678, 0,  5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{2'd0, 16'h3F80, 16'h3F80, 99, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{2'd1, 16'hFF80, 16'h7F80, 3,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{2'd2, 16'hC000, 16'hC000, 7,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{2'd0, 16'h7FC0, 16'h3F80, 1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    specials = '{16'h0000, 16'h8000, 16'h0001, 16'h8001, 16'h7F80, 16'hFF80,
                 16'h7FC0, 16'h7F81, 16'h3F80, 16'hBF80, 16'h0080};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    chk("reset outputs", 64'(allOuts), 64'd0);
    rst = 1'b0;
    step();
    chk("ready after reset", 64'(req_ready_o), 64'd1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      runOp(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].rdy, tbl[i].clr,
            gRes, gInv, gIll, gTo);
      chk($sformatf("tbl%0d result", i), 64'({gRes, gInv, gIll, gTo}),
          64'({tbl[i].eRes, tbl[i].eInv, tbl[i].eIll, tbl[i].eTo}));
    end

    // Sticky NV survives the table (set by vector 2, clear lost to set in 3).
    chk("NV still set", 64'(flagNV_o), 64'd1);
    flagClr_i = 1'b1;
    step();
    flagClr_i = 1'b0;
    nvModel = 1'b0;
    chk("NV cleared alone", 64'(flagNV_o), 64'd0);

    // Mid-flight reset during WAIT with NV set beforehand.
    runOp(2'd2, 16'h7FC0, 16'h3F80, 0, 0, 1'b0, gRes, gInv, gIll, gTo);
    req_valid_i = 1'b1; opcode_i = 2'd0; opA_i = 16'h3F80; opB_i = 16'h3F80;
    step();
    req_valid_i = 1'b0;
    step();
    step();
    step();
    chk("in WAIT before reset", 64'({res_valid_o, req_ready_o}), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvModel = 1'b0;
    chk("reset in WAIT outputs", 64'(allOuts), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no response after abort", 64'(res_valid_o), 64'd0);
    end
    chk("idle after abort", 64'(req_ready_o), 64'd1);

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  rop;
      logic [15:0] ra, rb;
      int gap;
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 10)] : 16'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 10)] : 16'($urandom);
      runOp(rop, ra, rb, int'($urandom_range(0, 9)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), gRes, gInv, gIll, gTo);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        isCmpValid_i = 1'($urandom_range(0, 1));
        cmp_i = 1'b1;
        isCmpInvalid_i = 1'b1;
        flagClr_i = 1'($urandom_range(0, 1));
        step();
        if (flagClr_i) nvModel = 1'b0;
        isCmpValid_i = 1'b0; cmp_i = 1'b0; isCmpInvalid_i = 1'b0; flagClr_i = 1'b0;
        chk("idle NV", 64'(flagNV_o), 64'(nvModel));
        chk("idle no response", 64'({res_valid_o, req_ready_o}), 64'b01);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
